// File: rtl/mem_stage_unit_pkg.sv
// Shared definitions for the MIPS MEM stage: FSM states, pc_sel encodings
// (also used by the fetch stage) and the MEM->WB bundle layout.
package mem_stage_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] PCSEL_PC4 = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_J   = 2'd2;
  localparam logic [1:0] PCSEL_JR  = 2'd3;

  typedef struct packed {
    logic        regwriteen;
    logic        memtoreg;
    logic        link;
    logic [31:0] aluout;
    logic [31:0] readdata;
    logic [31:0] pcplus4;
    logic [4:0]  writereg;
  } wb_bundle_t;

  // Register jumps outrank direct jumps, which outrank taken branches.
  function automatic logic [1:0] pc_select(input logic jumptoreg, input logic jump,
                                           input logic branch, input logic zero);
    logic [1:0] sel;
    if (jumptoreg) begin
      sel = PCSEL_JR;
    end else if (jump) begin
      sel = PCSEL_J;
    end else if (branch && zero) begin
      sel = PCSEL_BR;
    end else begin
      sel = PCSEL_PC4;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_stage_unit_pipe_mem2wb.sv
// MEM->WB pipeline register. A bubble clears the control bits but keeps the
// data fields; load data is only replaced when rd_valid_i marks a completed load.
module pipe_mem2wb
  import mem_stage_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       bubble_i,
  input  logic       rd_valid_i,
  input  wb_bundle_t d_i,
  output wb_bundle_t q_o
);

  wb_bundle_t wb_d;
  wb_bundle_t wb_q;

  // Next-state of the WB bundle.
  always_comb begin
    wb_d = wb_q;
    if (bubble_i) begin
      wb_d.regwriteen = 1'b0;
      wb_d.memtoreg   = 1'b0;
      wb_d.link       = 1'b0;
    end else begin
      wb_d          = d_i;
      wb_d.readdata = rd_valid_i ? d_i.readdata : wb_q.readdata;
    end
  end

  // WB register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign q_o = wb_q;

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: req/ack data-memory handshake with timeout, pipeline stall,
// branch/jump redirect select and the MEM->WB register.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_branch,
  input  logic        mem_jump,
  input  logic        mem_jumptoreg,
  input  logic        mem_zero,
  input  logic        mem_link,
  input  logic        mem_memwrite,
  input  logic        mem_memtoreg,
  input  logic        mem_regwriteen,
  input  logic [31:0] mem_aluout,
  input  logic [31:0] mem_memwritedata,
  input  logic [31:0] mem_pcplus4,
  input  logic [4:0]  mem_writereg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [1:0]  pc_sel,
  output logic        dmem_err,
  output logic        wb_regwriteen,
  output logic        wb_memtoreg,
  output logic        wb_link,
  output logic [31:0] wb_aluout,
  output logic [31:0] wb_readdata,
  output logic [31:0] wb_pcplus4,
  output logic [4:0]  wb_writereg
);

  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic access_s, req_s, stall_s, done_s, timed_out_s;
  wb_bundle_t wb_in_s, wb_out_s;

  assign access_s = mem_memwrite | mem_memtoreg;

  // Access FSM: next state, wait counter and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    done_s      = 1'b0;
    timed_out_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_s = access_s;
        if (access_s && dmem_ack) begin
          done_s = 1'b1;
        end else if (access_s) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
          stall_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        req_s = 1'b1;
        if (dmem_ack) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          done_s      = 1'b1;
          timed_out_s = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset forces the handshake and redirect idle even mid-access.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    pc_sel    = PCSEL_PC4;
    if (!reset) begin
      dmem_req  = req_s;
      mem_stall = stall_s;
      pc_sel    = stall_s ? PCSEL_PC4
                          : pc_select(mem_jumptoreg, mem_jump, mem_branch, mem_zero);
    end else begin
      dmem_req = 1'b0;
    end
  end

  assign dmem_we    = dmem_req & mem_memwrite;
  assign dmem_addr  = mem_aluout;
  assign dmem_wdata = mem_memwritedata;
  assign dmem_err   = err_q;

  assign wb_in_s = '{
    regwriteen: mem_regwriteen,
    memtoreg:   mem_memtoreg,
    link:       mem_link,
    aluout:     mem_aluout,
    readdata:   timed_out_s ? ERR_DATA : dmem_rdata,
    pcplus4:    mem_pcplus4,
    writereg:   mem_writereg
  };

  // A store that also has memtoreg set never captures load data.
  pipe_mem2wb u_mem2wb (
    .clk_i      (clk),
    .reset_i    (reset),
    .bubble_i   (mem_stall),
    .rd_valid_i (done_s & mem_memtoreg & ~mem_memwrite),
    .d_i        (wb_in_s),
    .q_o        (wb_out_s)
  );

  assign wb_regwriteen = wb_out_s.regwriteen;
  assign wb_memtoreg   = wb_out_s.memtoreg;
  assign wb_link       = wb_out_s.link;
  assign wb_aluout     = wb_out_s.aluout;
  assign wb_readdata   = wb_out_s.readdata;
  assign wb_pcplus4    = wb_out_s.pcplus4;
  assign wb_writereg   = wb_out_s.writereg;

endmodule
